// File: rtl/mips_defs_pkg.sv
// Shared MDU definitions: operand width, op encodings and sequencer states.
package mips_defs_pkg;

    localparam int unsigned MDU_XLEN  = 32;
    localparam int unsigned MDU_CNT_W = 5;

    typedef enum logic [2:0] {
        MDU_NOP   = 3'b000,
        MDU_MULT  = 3'b001,
        MDU_MULTU = 3'b010,
        MDU_DIV   = 3'b011,
        MDU_DIVU  = 3'b100,
        MDU_MTHI  = 3'b101,
        MDU_MTLO  = 3'b110
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_SIGN = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mdu_datapath.sv
// MDU datapath: shift-add multiplier, restoring divider and final sign fix-up.
// MDU_EARLY_TERM_EN enables the multiply early-exit indication.
module mdu_datapath
    import mips_defs_pkg::*;
#(
    parameter int unsigned XLEN = MDU_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            step_i,
    input  logic            is_div_i,
    input  logic            is_signed_i,
    input  logic            rt_zero_i,
    input  logic [XLEN-1:0] rs_i,
    input  logic [XLEN-1:0] rt_i,
    output logic [XLEN-1:0] res_hi_o,
    output logic [XLEN-1:0] res_lo_o,
    output logic            mul_last_o
);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic              div_q, div_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic              dbz_q, dbz_d;

    logic [XLEN-1:0]   rs_mag, rt_mag;
    logic [XLEN:0]     shifted, diff;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot, rem;

    always_comb begin
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        opb_d     = opb_q;
        div_d     = div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;

        rs_mag  = (is_signed_i && rs_i[XLEN-1]) ? -rs_i : rs_i;
        rt_mag  = (is_signed_i && rt_i[XLEN-1]) ? -rt_i : rt_i;
        // Divide view of acc: {remainder, dividend/quotient} shifting left together.
        shifted = acc_q[2*XLEN-1:XLEN-1];
        diff    = shifted - {1'b0, opb_q};

        if (start_i) begin
            div_d     = is_div_i;
            neg_res_d = is_signed_i & (rs_i[XLEN-1] ^ rt_i[XLEN-1]);
            neg_rem_d = is_signed_i & rs_i[XLEN-1];
            dbz_d     = is_div_i & rt_zero_i;
            opb_d     = rt_mag;
            if (is_div_i) begin
                mcand_d = '0;
                acc_d   = rt_zero_i ? {rs_i, {XLEN{1'b1}}} : {{XLEN{1'b0}}, rs_mag};
            end else begin
                mcand_d = {{XLEN{1'b0}}, rs_mag};
                acc_d   = '0;
            end
        end else if (step_i) begin
            if (div_q) begin
                if (!diff[XLEN]) begin
                    acc_d = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = {acc_q[2*XLEN-2:0], 1'b0};
                end
            end else begin
                if (opb_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d = mcand_q << 1;
                opb_d   = opb_q >> 1;
            end
        end
    end

    always_comb begin
        prod = neg_res_q ? -acc_q : acc_q;
        quot = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        if (!div_q) begin
            res_hi_o = prod[2*XLEN-1:XLEN];
            res_lo_o = prod[XLEN-1:0];
        end else if (dbz_q) begin
            res_hi_o = acc_q[2*XLEN-1:XLEN];
            res_lo_o = acc_q[XLEN-1:0];
        end else begin
            res_hi_o = rem;
            res_lo_o = quot;
        end
    end

`ifdef MDU_EARLY_TERM_EN
    assign mul_last_o = !div_q && (opb_q[XLEN-1:1] == '0);
`else
    assign mul_last_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            mcand_q   <= '0;
            opb_q     <= '0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            opb_q     <= opb_d;
            div_q     <= div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
        end
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative MULT/DIV sequencer owning HI/LO, with stall and done signalling.
// MDU_EARLY_TERM_EN lets multiplies finish once the remaining multiplier bits are zero.
module mdu_sequencer
    import mips_defs_pkg::*;
#(
    parameter int unsigned XLEN  = MDU_XLEN,
    parameter int unsigned CNT_W = MDU_CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs_i,
    input  logic [XLEN-1:0] rt_i,
    input  logic            mf_req_i,
    input  logic            flush_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o,
    output logic            busy_o,
    output logic            stall_o,
    output logic            done_o
);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic             done_q, done_d;

    logic             start, step;
    logic             is_mul_op, is_div_op, is_signed_op, rt_zero;
    logic [XLEN-1:0]  res_hi, res_lo;
    logic             mul_last;

    always_comb begin
        is_mul_op    = (op_i == MDU_MULT) || (op_i == MDU_MULTU);
        is_div_op    = (op_i == MDU_DIV)  || (op_i == MDU_DIVU);
        is_signed_op = (op_i == MDU_MULT) || (op_i == MDU_DIV);
        rt_zero      = (rt_i == '0);
    end

    mdu_datapath #(.XLEN(XLEN)) u_datapath (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .step_i      (step),
        .is_div_i    (is_div_op),
        .is_signed_i (is_signed_op),
        .rt_zero_i   (rt_zero),
        .rs_i        (rs_i),
        .rt_i        (rt_i),
        .res_hi_o    (res_hi),
        .res_lo_o    (res_lo),
        .mul_last_o  (mul_last)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        start   = 1'b0;
        step    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!flush_i) begin
                    if (is_mul_op || is_div_op) begin
                        start = 1'b1;
                        cnt_d = '0;
                        if (is_div_op && rt_zero) begin
                            state_d = ST_SIGN;
`ifdef MDU_EARLY_TERM_EN
                        end else if (is_mul_op && rt_zero) begin
                            state_d = ST_SIGN;
`endif
                        end else begin
                            state_d = ST_CALC;
                        end
                    end else if (op_i == MDU_MTHI) begin
                        hi_d = rs_i;
                    end else if (op_i == MDU_MTLO) begin
                        lo_d = rs_i;
                    end
                end
            end
            ST_CALC: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    step  = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if ((cnt_q == CNT_W'(XLEN - 1)) || mul_last) begin
                        state_d = ST_SIGN;
                    end
                end
            end
            ST_SIGN: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                if (!flush_i) begin
                    hi_d   = res_hi;
                    lo_d   = res_lo;
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign hi_o    = hi_q;
    assign lo_o    = lo_q;
    assign busy_o  = (state_q != ST_IDLE);
    assign stall_o = busy_o & ((op_i != MDU_NOP) | mf_req_i);
    assign done_o  = done_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: latency-counter reference model plus directed literals.
module tb_mdu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  op;
    logic [31:0] rs, rt;
    logic        mf, fl;
    logic [31:0] hi_o, lo_o;
    logic        busy_o, stall_o, done_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mdu_sequencer #(.XLEN(32), .CNT_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .op_i     (op),
        .rs_i     (rs),
        .rt_i     (rt),
        .mf_req_i (mf),
        .flush_i  (fl),
        .hi_o     (hi_o),
        .lo_o     (lo_o),
        .busy_o   (busy_o),
        .stall_o  (stall_o),
        .done_o   (done_o)
    );

    // Reference state: architectural HI/LO, edges left until the pending result lands.
    logic [31:0] m_hi = '0, m_lo = '0, m_res_hi = '0, m_res_lo = '0;
    int          m_left = 0;
    logic        m_done = 1'b0;
    bit          chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int top_bit(input logic [31:0] v);
        for (int i = 31; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_update();
        logic [63:0] p;
        logic [31:0] ma, mb, q, r;
        bit          sgn;
        int          lat;
        if (rst) begin
            m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                if (fl) m_left = 0;
                else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_hi = m_res_hi; m_lo = m_res_lo; m_done = 1'b1;
                    end
                end
            end else if (!fl) begin
                sgn = (op == 3'd1) || (op == 3'd3);
                ma  = (sgn && rs[31]) ? -rs : rs;
                mb  = (sgn && rt[31]) ? -rt : rt;
                lat = 33;
                case (op)
                    3'd1, 3'd2: begin
                        if (sgn) p = 64'(longint'(signed'(rs)) * longint'(signed'(rt)));
                        else     p = {32'b0, rs} * {32'b0, rt};
`ifdef MDU_EARLY_TERM_EN
                        lat = (mb == 0) ? 1 : top_bit(mb) + 2;
`endif
                        m_res_hi = p[63:32]; m_res_lo = p[31:0]; m_left = lat;
                    end
                    3'd3, 3'd4: begin
                        if (rt == 0) begin
                            m_res_hi = rs; m_res_lo = '1; m_left = 1;
                        end else begin
                            q = ma / mb; r = ma % mb;
                            if (sgn && (rs[31] ^ rt[31])) q = -q;
                            if (sgn && rs[31]) r = -r;
                            m_res_hi = r; m_res_lo = q; m_left = lat;
                        end
                    end
                    3'd5: m_hi = rs;
                    3'd6: m_lo = rs;
                    default: ;
                endcase
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("hi", hi_o, m_hi);
            check("lo", lo_o, m_lo);
            check("busy", 32'(busy_o), 32'(m_left > 0));
            check("done", 32'(done_o), 32'(m_done));
            check("stall", 32'(stall_o), 32'((m_left > 0) && (op != 3'd0 || mf)));
        end
    end

    task automatic step(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic m, input logic f, input logic r);
        op = o; rs = a; rt = b; mf = m; fl = f; rst = r;
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Issues one op and idles until busy drops; n = edges after acceptance.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic m, output int n);
        step(o, a, b, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (busy_o && n < 100) begin
            step(3'd0, '0, '0, m, 1'b0, 1'b0);
            n++;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 7)
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom % 300);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        op = '0; rs = '0; rt = '0; mf = 1'b0; fl = 1'b0; rst = 1'b1;
        step(3'd0, '0, '0, 1'b0, 1'b0, 1'b1);
        step(3'd0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        check("rst_hi", hi_o, 32'h0);
        check("rst_lo", lo_o, 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);

        run_op(3'd1, 32'hFFFF_FFFD, 32'd7, 1'b0, n);
`ifdef MDU_EARLY_TERM_EN
        check("mult_lat", n, 32'd4);
`else
        check("mult_lat", n, 32'd33);
`endif
        check("mult_hi", hi_o, 32'hFFFF_FFFF);
        check("mult_lo", lo_o, 32'hFFFF_FFEB);
        check("mult_done", 32'(done_o), 32'h1);

        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, n);
        check("multu_lat", n, 32'd33);
        check("multu_hi", hi_o, 32'hFFFF_FFFE);
        check("multu_lo", lo_o, 32'h0000_0001);

        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, n);
        check("div_lat", n, 32'd33);
        check("div_lo", lo_o, 32'hFFFF_FFFD);
        check("div_hi", hi_o, 32'hFFFF_FFFF);

        run_op(3'd4, 32'd7, 32'd0, 1'b0, n);
        check("divu0_lat", n, 32'd1);
        check("divu0_hi", hi_o, 32'd7);
        check("divu0_lo", lo_o, 32'hFFFF_FFFF);

        step(3'd1, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(3'd0, '0, '0, 1'b0, 1'b0, 1'b0);
        step(3'd0, '0, '0, 1'b1, 1'b0, 1'b0);
        check("mf_stall", 32'(stall_o), 32'h1);
        n = 0;
        while (busy_o && n < 100) begin
            step(3'd0, '0, '0, 1'b1, 1'b0, 1'b0);
            n++;
        end
        check("mf_stall_idle", 32'(stall_o), 32'h0);
        check("mf_hi", hi_o, 32'h0000_0001);
        check("mf_lo", lo_o, 32'h0);

        step(3'd5, 32'h0000_1234, '0, 1'b0, 1'b0, 1'b0);
        step(3'd4, 32'd1000, 32'd3, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step(3'd0, '0, '0, 1'b0, 1'b0, 1'b0);
        step(3'd0, '0, '0, 1'b0, 1'b1, 1'b0);
        check("flush_busy", 32'(busy_o), 32'h0);
        check("flush_hi", hi_o, 32'h0000_1234);
        step(3'd0, '0, '0, 1'b0, 1'b0, 1'b0);
        check("flush_done", 32'(done_o), 32'h0);

        step(3'd1, 32'h0000_0055, 32'h0000_00AA, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 19; i++) step(3'd0, '0, '0, 1'b0, 1'b0, 1'b0);
        step(3'd0, '0, '0, 1'b0, 1'b0, 1'b1);
        check("midrst_hi", hi_o, 32'h0);
        check("midrst_lo", lo_o, 32'h0);
        check("midrst_busy", 32'(busy_o), 32'h0);

        step(3'd6, 32'h0000_ABCD, '0, 1'b0, 1'b0, 1'b0);
        check("mtlo_lo", lo_o, 32'h0000_ABCD);
        check("mtlo_busy", 32'(busy_o), 32'h0);

        run_op(3'd1, 32'd9, 32'd1, 1'b0, n);
`ifdef MDU_EARLY_TERM_EN
        check("mult_rt1_lat", n, 32'd2);
`else
        check("mult_rt1_lat", n, 32'd33);
`endif
        check("mult_rt1_lo", lo_o, 32'd9);

        for (int i = 0; i < 3000; i++) begin
            logic [2:0] o;
            o = ($urandom % 10 < 4) ? 3'd0 : 3'($urandom_range(1, 6));
            step(o, pick(), pick(), 1'($urandom % 4 == 0), 1'($urandom % 40 == 0),
                 1'($urandom % 300 == 0));
        end
        step(3'd0, '0, '0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
